// File: rtl/ibex_rf_seq_pkg.sv
// Shared types and helpers for the FPGA register-file write sequencer.
package ibex_rf_seq_pkg;

  localparam int unsigned RfAddrW  = 5;
  localparam int unsigned RfDataW  = 32;
  localparam int unsigned WaitCntW = 8;

  typedef enum logic [0:0] {
    RfSeqClear = 1'b0,
    RfSeqRun   = 1'b1
  } rf_seq_state_e;

  typedef struct packed {
    logic               we;
    logic [RfAddrW-1:0] addr;
    logic [RfDataW-1:0] wdata;
  } rf_wr_req_t;

  // Number of architectural registers for the selected ISA variant.
  function automatic int unsigned num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_rf_write_sequencer_if.sv
// Core writeback and secondary req/gnt requester signals of the RF write sequencer.
interface ibex_rf_write_sequencer_if #(
  parameter int unsigned DataWidth = 32
);

  logic                 wb_we_i;
  logic [4:0]           wb_waddr_i;
  logic [DataWidth-1:0] wb_wdata_i;
  logic                 wb_stall_o;

  logic                 sec_req_i;
  logic [4:0]           sec_addr_i;
  logic [DataWidth-1:0] sec_wdata_i;
  logic                 sec_gnt_o;
  logic                 sec_err_o;

  modport master (
    output wb_we_i, wb_waddr_i, wb_wdata_i, sec_req_i, sec_addr_i, sec_wdata_i,
    input  wb_stall_o, sec_gnt_o, sec_err_o
  );

  modport slave (
    input  wb_we_i, wb_waddr_i, wb_wdata_i, sec_req_i, sec_addr_i, sec_wdata_i,
    output wb_stall_o, sec_gnt_o, sec_err_o
  );

endinterface

// File: rtl/ibex_rf_clear_counter.sv
// Register index walker for the clear pass: 1 .. NumWords-1, register 0 skipped.
module ibex_rf_clear_counter
  import ibex_rf_seq_pkg::*;
#(
  parameter int unsigned NumWords = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               restart_i,
  output logic [RfAddrW-1:0] idx_o,
  output logic               done_c
);

  localparam logic [RfAddrW-1:0] LastIdx = RfAddrW'(NumWords - 1);

  logic [RfAddrW-1:0] idx_q, idx_d;

  // Next index: restart wins, wrap back to 1 after the last register.
  always_comb begin
    idx_d = idx_q;
    if (restart_i) begin
      idx_d = RfAddrW'(1);
    end else if (en_i) begin
      idx_d = done_c ? RfAddrW'(1) : idx_q + RfAddrW'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= RfAddrW'(1);
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign done_c = (idx_q == LastIdx);

endmodule

// File: rtl/ibex_rf_write_sequencer.sv
// Owner of the FPGA register-file write port: clears every register after reset or
// on request, then arbitrates core writeback against a secondary req/gnt requester.
// Optional macro IBEX_RF_SEQ_FAIRNESS_EN adds a starvation counter that lets the
// secondary win over writeback after MaxWait ungranted cycles.
module ibex_rf_write_sequencer
  import ibex_rf_seq_pkg::*;
#(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = RfDataW,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          MaxWait     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_req_i,
  output logic                       rf_ready_o,
  ibex_rf_write_sequencer_if.slave   bus,
  output logic                       rf_we_o,
  output logic [RfAddrW-1:0]         rf_waddr_o,
  output logic [DataWidth-1:0]       rf_wdata_o
);

  localparam int unsigned NumWords = num_words(RV32E);

  // Elaboration-time marker for an out-of-range starvation limit.
  if ((MaxWait < 1) || (MaxWait > 255)) begin : gen_max_wait_out_of_range
  end

  rf_seq_state_e      state_q, state_d;
  rf_wr_req_t         rf_wr;
  logic [RfAddrW-1:0] clr_idx;
  logic               clr_done;
  logic               sec_win;

`ifdef IBEX_RF_SEQ_FAIRNESS_EN
  logic [WaitCntW-1:0] wait_q, wait_d;
`endif

  ibex_rf_clear_counter #(
    .NumWords(NumWords)
  ) u_clear_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (state_q == RfSeqClear),
    .restart_i(clear_req_i),
    .idx_o    (clr_idx),
    .done_c   (clr_done)
  );

  // Next state and combinational write-port arbitration.
  always_comb begin
    state_d        = state_q;
    rf_wr          = '0;
    rf_ready_o     = 1'b0;
    sec_win        = 1'b0;
    bus.sec_gnt_o  = 1'b0;
    bus.sec_err_o  = 1'b0;
    bus.wb_stall_o = 1'b0;
`ifdef IBEX_RF_SEQ_FAIRNESS_EN
    wait_d         = wait_q;
`endif
    case (state_q)
      RfSeqClear: begin
        // Hold the port quiet while reset is asserted.
        if (rst_ni) begin
          rf_wr.we    = 1'b1;
          rf_wr.addr  = clr_idx;
          rf_wr.wdata = RfDataW'(WordZeroVal);
        end
        if (!clear_req_i && clr_done) begin
          state_d = RfSeqRun;
        end
      end
      RfSeqRun: begin
        rf_ready_o = 1'b1;
`ifdef IBEX_RF_SEQ_FAIRNESS_EN
        sec_win = bus.sec_req_i &
                  (~bus.wb_we_i | (wait_q == WaitCntW'(MaxWait)));
        bus.wb_stall_o = bus.wb_we_i & sec_win;
        if (!bus.sec_req_i || sec_win) begin
          wait_d = '0;
        end else if (wait_q != {WaitCntW{1'b1}}) begin
          wait_d = wait_q + WaitCntW'(1);
        end
`else
        sec_win = bus.sec_req_i & ~bus.wb_we_i;
`endif
        if (sec_win) begin
          bus.sec_gnt_o = 1'b1;
          // Upper half of the index space does not exist in RV32E.
          if (RV32E && bus.sec_addr_i[4]) begin
            bus.sec_err_o = 1'b1;
          end else begin
            rf_wr.we    = 1'b1;
            rf_wr.addr  = bus.sec_addr_i;
            rf_wr.wdata = RfDataW'(bus.sec_wdata_i);
          end
        end else if (bus.wb_we_i) begin
          rf_wr.we    = 1'b1;
          rf_wr.addr  = bus.wb_waddr_i;
          rf_wr.wdata = RfDataW'(bus.wb_wdata_i);
        end
        if (clear_req_i) begin
          state_d = RfSeqClear;
        end
      end
      default: state_d = RfSeqClear;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RfSeqClear;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef IBEX_RF_SEQ_FAIRNESS_EN
  // Secondary starvation counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign rf_we_o    = rf_wr.we;
  assign rf_waddr_o = rf_wr.addr;
  assign rf_wdata_o = DataWidth'(rf_wr.wdata);

endmodule

// File: tb/tb_ibex_rf_write_sequencer.sv
// Bench for ibex_rf_write_sequencer: an RV32I and an RV32E instance checked every
// cycle against a queue-based model of clear passes and write-port arbitration.
module tb_ibex_rf_write_sequencer;

  localparam int unsigned MaxWait = 4;
  localparam logic [31:0] ZeroVal = 32'hDEAD_BEEF;
`ifdef IBEX_RF_SEQ_FAIRNESS_EN
  localparam bit FairEn = 1'b1;
`else
  localparam bit FairEn = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic        clear_req [2];
  logic        wb_we     [2];
  logic [4:0]  wb_waddr  [2];
  logic [31:0] wb_wdata  [2];
  logic        sec_req   [2];
  logic [4:0]  sec_addr  [2];
  logic [31:0] sec_wdata [2];

  logic        o_rdy0, o_we0, o_rdy1, o_we1;
  logic [4:0]  o_waddr0, o_waddr1;
  logic [31:0] o_wdata0, o_wdata1;

  ibex_rf_write_sequencer_if #(.DataWidth(32)) bus0 ();
  ibex_rf_write_sequencer_if #(.DataWidth(32)) bus1 ();

  assign bus0.wb_we_i     = wb_we[0];
  assign bus0.wb_waddr_i  = wb_waddr[0];
  assign bus0.wb_wdata_i  = wb_wdata[0];
  assign bus0.sec_req_i   = sec_req[0];
  assign bus0.sec_addr_i  = sec_addr[0];
  assign bus0.sec_wdata_i = sec_wdata[0];
  assign bus1.wb_we_i     = wb_we[1];
  assign bus1.wb_waddr_i  = wb_waddr[1];
  assign bus1.wb_wdata_i  = wb_wdata[1];
  assign bus1.sec_req_i   = sec_req[1];
  assign bus1.sec_addr_i  = sec_addr[1];
  assign bus1.sec_wdata_i = sec_wdata[1];

  ibex_rf_write_sequencer #(
    .RV32E(1'b0), .DataWidth(32), .WordZeroVal(ZeroVal), .MaxWait(MaxWait)
  ) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_req_i(clear_req[0]), .rf_ready_o(o_rdy0),
    .bus(bus0), .rf_we_o(o_we0), .rf_waddr_o(o_waddr0), .rf_wdata_o(o_wdata0)
  );

  ibex_rf_write_sequencer #(
    .RV32E(1'b1), .DataWidth(32), .WordZeroVal(ZeroVal), .MaxWait(MaxWait)
  ) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_req_i(clear_req[1]), .rf_ready_o(o_rdy1),
    .bus(bus1), .rf_we_o(o_we1), .rf_waddr_o(o_waddr1), .rf_wdata_o(o_wdata1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending clear writes, starvation count, last grant per instance.
  int clear_q [2][$];
  int wait_cnt [2];
  bit last_gnt [2];

  function automatic int nwords(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refill(input int i);
    clear_q[i].delete();
    for (int a = 1; a < nwords(i); a++) clear_q[i].push_back(a);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      refill(i);
      wait_cnt[i] = 0;
      last_gnt[i] = 1'b0;
    end
  endtask

  task automatic read_dut(input int i, output logic rdy, output logic we, output logic [4:0] wa,
                          output logic [31:0] wd, output logic gnt, output logic err,
                          output logic stall);
    if (i == 0) begin
      rdy = o_rdy0; we = o_we0; wa = o_waddr0; wd = o_wdata0;
      gnt = bus0.sec_gnt_o; err = bus0.sec_err_o; stall = bus0.wb_stall_o;
    end else begin
      rdy = o_rdy1; we = o_we1; wa = o_waddr1; wd = o_wdata1;
      gnt = bus1.sec_gnt_o; err = bus1.sec_err_o; stall = bus1.wb_stall_o;
    end
  endtask

  task automatic check_reset_outputs();
    logic rdy, we, gnt, err, stall;
    logic [4:0] wa;
    logic [31:0] wd;
    for (int i = 0; i < 2; i++) begin
      read_dut(i, rdy, we, wa, wd, gnt, err, stall);
      chk($sformatf("rst%0d rf_we", i), 32'(we), 32'd0);
      chk($sformatf("rst%0d ready", i), 32'(rdy), 32'd0);
      chk($sformatf("rst%0d gnt", i), 32'(gnt), 32'd0);
      chk($sformatf("rst%0d err", i), 32'(err), 32'd0);
      chk($sformatf("rst%0d stall", i), 32'(stall), 32'd0);
      chk($sformatf("rst%0d waddr", i), 32'(wa), 32'd0);
      chk($sformatf("rst%0d wdata", i), wd, 32'd0);
    end
  endtask

  // One clock: compare against the model at the falling edge, then advance the model.
  task automatic step();
    logic rdy, we, gnt, err, stall;
    logic [4:0] wa;
    logic [31:0] wd;
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      bit e_we, e_gnt, e_err, e_stall, e_rdy, forced, running;
      int e_addr;
      logic [31:0] e_data;
      e_we = 0; e_gnt = 0; e_err = 0; e_stall = 0; e_rdy = 0; e_addr = 0; e_data = '0;
      running = (clear_q[i].size() == 0);
      if (!running) begin
        e_we = 1; e_addr = clear_q[i][0]; e_data = ZeroVal;
      end else begin
        e_rdy  = 1;
        forced = FairEn && sec_req[i] && (wait_cnt[i] == MaxWait);
        if (sec_req[i] && (!wb_we[i] || forced)) begin
          e_gnt   = 1;
          e_stall = wb_we[i];
          if ((i == 1) && (sec_addr[i] >= 5'd16)) e_err = 1;
          else begin e_we = 1; e_addr = int'(sec_addr[i]); e_data = sec_wdata[i]; end
        end else if (wb_we[i]) begin
          e_we = 1; e_addr = int'(wb_waddr[i]); e_data = wb_wdata[i];
        end
      end
      read_dut(i, rdy, we, wa, wd, gnt, err, stall);
      chk($sformatf("i%0d ready", i), 32'(rdy), 32'(e_rdy));
      chk($sformatf("i%0d rf_we", i), 32'(we), 32'(e_we));
      chk($sformatf("i%0d gnt", i), 32'(gnt), 32'(e_gnt));
      chk($sformatf("i%0d err", i), 32'(err), 32'(e_err));
      chk($sformatf("i%0d stall", i), 32'(stall), 32'(e_stall));
      if (e_we) begin
        chk($sformatf("i%0d waddr", i), 32'(wa), 32'(e_addr));
        chk($sformatf("i%0d wdata", i), wd, e_data);
      end
      if (!running) void'(clear_q[i].pop_front());
      else if (!sec_req[i] || e_gnt) wait_cnt[i] = 0;
      else if (wait_cnt[i] < 255) wait_cnt[i]++;
      if (clear_req[i]) refill(i);
      last_gnt[i] = e_gnt;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      clear_req[i] = 0; wb_we[i] = 0; wb_waddr[i] = '0; wb_wdata[i] = '0;
      sec_req[i] = 0; sec_addr[i] = '0; sec_wdata[i] = '0;
    end
  endtask

  task automatic drop_granted();
    for (int i = 0; i < 2; i++) if (last_gnt[i]) sec_req[i] = 0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) begin
      wb_we[i]    = 1'($urandom_range(0, 1));
      wb_waddr[i] = 5'($urandom_range(0, 31));
      wb_wdata[i] = $urandom;
      if (sec_req[i] && !last_gnt[i]) begin
        if ($urandom_range(0, 15) == 0) sec_req[i] = 0;
      end else begin
        sec_req[i]   = ($urandom_range(0, 2) != 0);
        sec_addr[i]  = 5'($urandom_range(0, 31));
        sec_wdata[i] = $urandom;
      end
      clear_req[i] = ($urandom_range(0, 99) == 0);
    end
  endtask

  initial begin
    set_idle();
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Clear pass after reset, then one RUN cycle on the larger instance.
    repeat (32) step();

    // Writeback and secondary together: writeback first, then the grant.
    for (int i = 0; i < 2; i++) begin
      wb_we[i] = 1; wb_waddr[i] = 5'd5; wb_wdata[i] = 32'h11;
      sec_req[i] = 1; sec_addr[i] = 5'd7; sec_wdata[i] = 32'h22;
    end
    step();
    for (int i = 0; i < 2; i++) wb_we[i] = 0;
    step();
    set_idle();

    // Upper-half secondary address: suppressed on RV32E, written on RV32I.
    for (int i = 0; i < 2; i++) begin
      sec_req[i] = 1; sec_addr[i] = 5'd20; sec_wdata[i] = 32'h55;
    end
    step();
    set_idle();
    step();

    // Clear request while writeback hits reg3, secondary pending across the pass.
    for (int i = 0; i < 2; i++) begin
      clear_req[i] = 1; wb_we[i] = 1; wb_waddr[i] = 5'd3; wb_wdata[i] = 32'h33;
      sec_req[i] = 1; sec_addr[i] = 5'd9; sec_wdata[i] = 32'h99;
    end
    step();
    for (int i = 0; i < 2; i++) begin clear_req[i] = 0; wb_we[i] = 0; end
    repeat (33) begin step(); drop_granted(); end
    set_idle();

    // Writeback held against a held secondary request.
    for (int i = 0; i < 2; i++) begin
      wb_we[i] = 1; wb_waddr[i] = 5'd6; wb_wdata[i] = 32'h66;
      sec_req[i] = 1; sec_addr[i] = 5'd11; sec_wdata[i] = 32'hAB;
    end
    repeat (7) begin step(); drop_granted(); end
    set_idle();
    step();

    // Clear request inside a clear pass restarts it.
    for (int i = 0; i < 2; i++) clear_req[i] = 1;
    step();
    for (int i = 0; i < 2; i++) clear_req[i] = 0;
    repeat (10) step();
    for (int i = 0; i < 2; i++) clear_req[i] = 1;
    step();
    for (int i = 0; i < 2; i++) clear_req[i] = 0;
    repeat (5) step();

    // Asynchronous reset in the middle of a pass.
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (34) step();

    // Randomised traffic.
    repeat (500) begin
      rand_inputs();
      step();
    end

    set_idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
